// File: rtl/hamming_snapshot_tx.sv
// hamming_snapshot_tx
//   Captures a snapshot of an external free-running counter whenever the
//   counting stage is switched off (falling edge of enable). It computes a
//   Hamming(7,4) parity triple for every 4-bit block of the snapshot and
//   streams a fixed-length frame of 16-bit words over a valid/ready
//   handshake:
//     word 0                  : {8'hA5, seq}
//     words 1 .. WIDTH/16     : snapshot, least-significant slice first
//     next PWORDS words       : parity, least-significant slice first,
//                               zero-padded above PARITY_BITS
//
// Ports
//   clk       rising-edge clock for all state
//   rst       synchronous, active-low reset
//   enable    counting-stage enable; its falling edge requests a snapshot
//   counter   live counter value (WIDTH bits)
//   clr_ovr   clears the sticky overrun flag
//   tx_ready  downstream accepts the current word
//   tx_valid  tx_data carries a frame word
//   tx_data   frame word (16 bits)
//   tx_last   final word of the frame
//   overrun   sticky; a snapshot request arrived while a frame was busy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a snapshot request; snapshot latched on the request
// LOAD  | parity computed from the latched snapshot, word index cleared
// SEND  | frame words presented; index advances on each accepted word
module hamming_snapshot_tx #(
  parameter int WIDTH       = 64,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int PWORDS      = (PARITY_BITS + 15) / 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] counter,
  input  logic             clr_ovr,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [15:0]      tx_data,
  output logic             tx_last,
  output logic             overrun
);

  localparam int CWORDS    = WIDTH / 16;
  localparam int FRAME_LEN = 1 + CWORDS + PWORDS;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   en_prev_q, en_prev_d;   // enable delayed one cycle
  logic [WIDTH-1:0]       snap_cnt_q, snap_cnt_d;
  logic [PARITY_BITS-1:0] parity_q, parity_d;
  logic [7:0]             seq_q, seq_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   overrun_q, overrun_d;

  logic                   req;
  logic                   drop;
  logic [16*PWORDS-1:0]   par_pad;
  logic [15:0]            frame_w [FRAME_LEN];

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      en_prev_q  <= 1'b0;
      snap_cnt_q <= '0;
      parity_q   <= '0;
      seq_q      <= '0;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= en_prev_d;
      snap_cnt_q <= snap_cnt_d;
      parity_q   <= parity_d;
      seq_q      <= seq_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    en_prev_d  = enable;
    snap_cnt_d = snap_cnt_q;
    parity_d   = parity_q;
    seq_d      = seq_q;
    idx_d      = idx_q;
    drop       = 1'b0;

    // en_prev_q is cleared by reset, so enable already low after release
    // cannot look like a falling edge.
    req = en_prev_q && !enable;

    case (state_q)
      IDLE: begin
        if (req) begin
          snap_cnt_d = counter;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        for (int i = 0; i < BLOCKS; i++) begin
          parity_d[3*i+2] = snap_cnt_q[4*i] ^ snap_cnt_q[4*i+2] ^ snap_cnt_q[4*i+3];
          parity_d[3*i+1] = snap_cnt_q[4*i] ^ snap_cnt_q[4*i+1] ^ snap_cnt_q[4*i+3];
          parity_d[3*i]   = snap_cnt_q[4*i] ^ snap_cnt_q[4*i+1] ^ snap_cnt_q[4*i+2];
        end
        idx_d   = '0;
        state_d = SEND;
        drop    = req;
      end

      SEND: begin
        // A request on the very edge that accepts the last word is still
        // a drop: the FSM is busy until that edge has passed.
        drop = req;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            seq_d   = seq_q + 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A drop wins over a simultaneous clear so no lost request goes unseen.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // ------------------------------------------------------------------
  // Output decode (registered state only; tx_ready never reaches here)
  // ------------------------------------------------------------------
  always_comb begin
    par_pad                  = '0;
    par_pad[PARITY_BITS-1:0] = parity_q;

    for (int k = 0; k < FRAME_LEN; k++) begin
      frame_w[k] = '0;
    end
    frame_w[0] = {8'hA5, seq_q};
    for (int j = 0; j < CWORDS; j++) begin
      frame_w[1+j] = snap_cnt_q[16*j +: 16];
    end
    for (int j = 0; j < PWORDS; j++) begin
      frame_w[1+CWORDS+j] = par_pad[16*j +: 16];
    end

    tx_valid = (state_q == SEND);
    tx_last  = tx_valid && (idx_q == LAST_IDX);
    tx_data  = '0;
    if (tx_valid) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (idx_q == IDX_W'(k)) begin
          tx_data = frame_w[k];
        end
      end
    end
    overrun = overrun_q;
  end

endmodule

// File: doc/hamming_snapshot_tx.md
HAMMING_SNAPSHOT_TX -- requirements
Module: hamming_snapshot_tx

Interface
REQ-001 Parameter: WIDTH, 64, counter width; SHALL be a multiple of 16.
REQ-002 Parameter: BLOCKS, WIDTH/4, number of 4-bit Hamming blocks.
REQ-003 Parameter: PARITY_BITS, BLOCKS*3, parity bits per snapshot.
REQ-004 Parameter: PWORDS, ceil(PARITY_BITS/16), parity words per frame.
REQ-005 Port: clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-006 Port: rst  in  1  reset, synchronous, active-low.
REQ-007 Port: enable  in  1  counting-stage enable, same signal driven to the counter/parity stage.
REQ-008 Port: counter  in  WIDTH  counter value from the counter/parity stage.
REQ-009 Port: clr_ovr  in  1  clears the sticky overrun flag.
REQ-010 Port: tx_ready  in  1  downstream accepts the current word.
REQ-011 Port: tx_valid  out  1  tx_data holds a valid word.
REQ-012 Port: tx_data  out  16  frame word.
REQ-013 Port: tx_last  out  1  marks the final word of a frame.
REQ-014 Port: overrun  out  1  sticky; a snapshot request was dropped.

Function
REQ-015 SHALL register enable into enable_d each cycle; snapshot request = enable_d && !enable.
REQ-016 FSM states SHALL be IDLE, LOAD, SEND.
REQ-017 IDLE + request: counter SHALL be latched into snap_cnt on that edge; next state SHALL be LOAD.
REQ-018 LOAD: per block i, parity SHALL be registered as p[3i+2]=c[4i]^c[4i+2]^c[4i+3], p[3i+1]=c[4i]^c[4i+1]^c[4i+3], p[3i]=c[4i]^c[4i+1]^c[4i+2], taken from snap_cnt; next state SHALL be SEND with word index 0.
REQ-019 tx_valid SHALL be 1 exactly while in SEND; first word valid 2 cycles after the edge where the request was sampled.
REQ-020 Frame order: word 0 = {8'hA5, seq[7:0]}; words 1..WIDTH/16 = snap_cnt 16-bit slices, LS slice first; then PWORDS parity words, LS first, zero-padded above PARITY_BITS.
REQ-021 Frame length SHALL be 1+WIDTH/16+PWORDS words; 8 for defaults.
REQ-022 Word index SHALL advance only on tx_valid && tx_ready; tx_data/tx_last SHALL stay stable while tx_valid && !tx_ready.
REQ-023 tx_last SHALL be 1 only on the final word; when it is accepted the FSM SHALL return to IDLE and seq SHALL increment mod 256.
REQ-024 A request in LOAD or SEND SHALL be dropped, SHALL NOT disturb snap_cnt or the frame in flight, and SHALL set overrun.
REQ-025 A request on the same cycle as final-word acceptance SHALL count as overrun; no back-to-back start.
REQ-026 clr_ovr SHALL clear overrun next edge; simultaneous clr_ovr and new drop SHALL leave overrun = 1.
REQ-027 Outputs SHALL be registered or decoded from registered state only; no combinational path from tx_ready to tx_valid.

Reset
REQ-028 With rst = 0 at a rising edge: state = IDLE, tx_valid = 0, tx_last = 0, tx_data = 0, overrun = 0, seq = 0, enable_d = 0, snap_cnt = 0, parity = 0.
REQ-029 Reset mid-frame SHALL abort the frame; tx_valid SHALL be 0 after that edge with no partial completion or seq increment.
REQ-030 A request SHALL NOT be detected on the first cycle after reset release if enable is already 0.

Verification
REQ-031 counter=64'h5, enable 1->0, tx_ready=1 -> 8 words: A500, 0005, 0000, 0000, 0000, 0002, 0000, 0000; tx_last on word 8; seq becomes 1.
REQ-032 counter=64'hFFFF_FFFF_FFFF_FFFF -> parity words FFFF, FFFF, FFFF (every block 3'b111); counter words all FFFF.
REQ-033 tx_ready toggled 1-0-0-1 per cycle -> each word held stable while stalled; no word skipped or repeated.
REQ-034 Second enable falling edge during SEND -> frame unchanged, overrun = 1 until clr_ovr pulse, then 0.
REQ-035 256 back-to-back frames -> header of frame 257 = A500 (seq wrap).
REQ-036 rst = 0 asserted during word 3 -> tx_valid = 0 next cycle; next frame header = A500.
